// File: rtl/axi_bridge_pkg.sv
// ---------------------------------------------------------------------------
// axi_bridge_pkg
// Shared constants, types and helpers for the core data-bus to AXI4 bridge.
//   RESP_*      : AXI response encodings
//   BURST_INCR  : AXI INCR burst encoding
//   axsize()    : AxSIZE encoding for a given data-bus width in bits
//   ax_payload_t / w_payload_t : request payload layouts for the default
//                 bus geometry (32-bit address/data, 8-bit ID)
// ---------------------------------------------------------------------------
package axi_bridge_pkg;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_EXOKAY = 2'b01;
  localparam logic [1:0] RESP_SLVERR = 2'b10;
  localparam logic [1:0] RESP_DECERR = 2'b11;
  localparam logic [1:0] BURST_INCR  = 2'b01;

  localparam int unsigned DEF_ADDR_W = 32;
  localparam int unsigned DEF_DATA_W = 32;
  localparam int unsigned DEF_ID_W   = 8;

  // Bytes per beat is DATA_W/8; AxSIZE is its log2.
  function automatic logic [2:0] axsize(input int unsigned data_w);
    logic [2:0] sz;
    sz = 3'd0;
    for (int unsigned i = 0; i < 8; i++) begin
      if ((32'd8 << i) == data_w) sz = 3'(i);
    end
    return sz;
  endfunction

  typedef struct packed {
    logic [DEF_ADDR_W-1:0] addr;
    logic [DEF_ID_W-1:0]   id;
  } ax_payload_t;

  typedef struct packed {
    logic [DEF_DATA_W-1:0]   data;
    logic [DEF_DATA_W/8-1:0] strb;
    logic                    last;
  } w_payload_t;

endpackage

// File: rtl/axi_fwd_slice.sv
// ---------------------------------------------------------------------------
// axi_fwd_slice
// One-entry forward register slice for a valid/ready channel. Full
// throughput: a new beat is accepted in the same cycle the held beat leaves.
//   clk_i, rst_ni      : clock, asynchronous active-low reset
//   en_i               : extra acceptance qualifier (credit gating)
//   s_valid_i/s_ready_o/s_data_i : upstream side
//   m_valid_o/m_ready_i/m_data_o : downstream side (registered)
//   full_o             : slice holds a beat
// ---------------------------------------------------------------------------
module axi_fwd_slice #(
  parameter int unsigned WIDTH = 8
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             en_i,
  input  logic             s_valid_i,
  output logic             s_ready_o,
  input  logic [WIDTH-1:0] s_data_i,
  output logic             m_valid_o,
  input  logic             m_ready_i,
  output logic [WIDTH-1:0] m_data_o,
  output logic             full_o
);

  logic             full_q, full_d;
  logic [WIDTH-1:0] data_q;
  logic             load;

  assign s_ready_o = (!full_q || m_ready_i) && en_i;
  assign load      = s_valid_i && s_ready_o;

  always_comb begin
    full_d = full_q;
    if (load)           full_d = 1'b1;
    else if (m_ready_i) full_d = 1'b0;
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) full_q <= 1'b0;
    else         full_q <= full_d;
  end

  // Payload only moves on a load, so it is stable while stalled downstream.
  always_ff @(posedge clk_i) begin
    if (load) data_q <= s_data_i;
  end

  assign m_valid_o = full_q;
  assign m_data_o  = data_q;
  assign full_o    = full_q;

endmodule

// File: rtl/axi_dbus_bridge.sv
// ---------------------------------------------------------------------------
// axi_dbus_bridge
// Bridge from the core's single-beat data-bus AXI master to a full AXI4
// system port. AW/W/AR pass through one-entry slices; B/R are combinational.
// Outstanding reads and writes are each limited to MAX_OUTST. The first
// non-OKAY response is captured (sticky) and all are counted (saturating).
//   clk, rst (async, active-low)
//   s_aw_*, s_w_*, s_b_*, s_ar_*, s_r_*  : core side
//   m_aw_*, m_w_*, m_b_*, m_ar_*, m_r_*  : system side
//   err_valid/resp/id/is_wr, err_cnt, err_clear : error capture
//   idle : nothing outstanding and all slices empty
// Optional: define DBUS_BRIDGE_PERF_EN to add perf_rd_stall, perf_wr_stall
// and perf_rd_lat_max counters.
// ---------------------------------------------------------------------------
module axi_dbus_bridge
  import axi_bridge_pkg::*;
#(
  parameter int unsigned ADDR_W    = 32,
  parameter int unsigned DATA_W    = 32,
  parameter int unsigned ID_W      = 8,
  parameter int unsigned MAX_OUTST = 4,
  parameter logic [2:0]  PROT      = 3'b000
) (
  input  logic                clk,
  input  logic                rst,
  // core write address
  input  logic                s_aw_valid,
  output logic                s_aw_ready,
  input  logic [ADDR_W-1:0]   s_aw_addr,
  input  logic [ID_W-1:0]     s_aw_id,
  // core write data
  input  logic                s_w_valid,
  output logic                s_w_ready,
  input  logic [DATA_W-1:0]   s_w_data,
  input  logic [DATA_W/8-1:0] s_w_strb,
  input  logic                s_w_last,
  // core write response
  output logic                s_b_valid,
  input  logic                s_b_ready,
  output logic [ID_W-1:0]     s_b_id,
  output logic [1:0]          s_b_resp,
  // core read address
  input  logic                s_ar_valid,
  output logic                s_ar_ready,
  input  logic [ADDR_W-1:0]   s_ar_addr,
  input  logic [ID_W-1:0]     s_ar_id,
  // core read data
  output logic                s_r_valid,
  input  logic                s_r_ready,
  output logic [DATA_W-1:0]   s_r_data,
  output logic [ID_W-1:0]     s_r_id,
  output logic [1:0]          s_r_resp,
  output logic                s_r_last,
  // system write address
  output logic                m_aw_valid,
  input  logic                m_aw_ready,
  output logic [ADDR_W-1:0]   m_aw_addr,
  output logic [ID_W-1:0]     m_aw_id,
  output logic [7:0]          m_aw_len,
  output logic [2:0]          m_aw_size,
  output logic [1:0]          m_aw_burst,
  output logic [2:0]          m_aw_prot,
  // system write data
  output logic                m_w_valid,
  input  logic                m_w_ready,
  output logic [DATA_W-1:0]   m_w_data,
  output logic [DATA_W/8-1:0] m_w_strb,
  output logic                m_w_last,
  // system write response
  input  logic                m_b_valid,
  output logic                m_b_ready,
  input  logic [ID_W-1:0]     m_b_id,
  input  logic [1:0]          m_b_resp,
  // system read address
  output logic                m_ar_valid,
  input  logic                m_ar_ready,
  output logic [ADDR_W-1:0]   m_ar_addr,
  output logic [ID_W-1:0]     m_ar_id,
  output logic [7:0]          m_ar_len,
  output logic [2:0]          m_ar_size,
  output logic [1:0]          m_ar_burst,
  output logic [2:0]          m_ar_prot,
  // system read data
  input  logic                m_r_valid,
  output logic                m_r_ready,
  input  logic [DATA_W-1:0]   m_r_data,
  input  logic [ID_W-1:0]     m_r_id,
  input  logic [1:0]          m_r_resp,
  input  logic                m_r_last,
  // error capture
  output logic                err_valid,
  output logic [1:0]          err_resp,
  output logic [ID_W-1:0]     err_id,
  output logic                err_is_wr,
  output logic [7:0]          err_cnt,
  input  logic                err_clear,
  output logic                idle
`ifdef DBUS_BRIDGE_PERF_EN
  ,
  output logic [31:0]         perf_rd_stall,
  output logic [31:0]         perf_wr_stall,
  output logic [15:0]         perf_rd_lat_max
`endif
);

  localparam int unsigned AX_W  = ADDR_W + ID_W;
  localparam int unsigned W_W   = DATA_W + DATA_W / 8 + 1;
  localparam int unsigned CNT_W = $clog2(MAX_OUTST + 1);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(MAX_OUTST);

  logic [CNT_W-1:0] rd_cnt_q, rd_cnt_d, wr_cnt_q, wr_cnt_d;
  logic             aw_full, w_full, ar_full;
  logic             aw_hs, ar_hs, b_hs, r_last_hs, b_err, r_err;

  logic             err_valid_q, err_valid_d, err_is_wr_q, err_is_wr_d;
  logic [1:0]       err_resp_q, err_resp_d;
  logic [ID_W-1:0]  err_id_q, err_id_d;
  logic [7:0]       err_cnt_q, err_cnt_d;
  logic [8:0]       err_sum;

  // Counter step: simultaneous inc/dec cancel; a lone decrement at zero holds.
  function automatic logic [CNT_W-1:0] cnt_next(input logic [CNT_W-1:0] c,
                                                input logic inc, input logic dec);
    logic [CNT_W-1:0] n;
    n = c;
    if (inc && !dec)                 n = c + CNT_W'(1);
    else if (dec && !inc && c != '0) n = c - CNT_W'(1);
    return n;
  endfunction

  function automatic logic [7:0] sat_add8(input logic [8:0] sum);
    return sum[8] ? 8'hFF : sum[7:0];
  endfunction

  // Request slices; AW/AR acceptance is credit-gated on the registered count.
  axi_fwd_slice #(.WIDTH(AX_W)) u_aw_slice (
    .clk_i(clk), .rst_ni(rst), .en_i(wr_cnt_q < CNT_MAX),
    .s_valid_i(s_aw_valid), .s_ready_o(s_aw_ready), .s_data_i({s_aw_addr, s_aw_id}),
    .m_valid_o(m_aw_valid), .m_ready_i(m_aw_ready), .m_data_o({m_aw_addr, m_aw_id}),
    .full_o(aw_full)
  );

  axi_fwd_slice #(.WIDTH(W_W)) u_w_slice (
    .clk_i(clk), .rst_ni(rst), .en_i(1'b1),
    .s_valid_i(s_w_valid), .s_ready_o(s_w_ready), .s_data_i({s_w_data, s_w_strb, s_w_last}),
    .m_valid_o(m_w_valid), .m_ready_i(m_w_ready), .m_data_o({m_w_data, m_w_strb, m_w_last}),
    .full_o(w_full)
  );

  axi_fwd_slice #(.WIDTH(AX_W)) u_ar_slice (
    .clk_i(clk), .rst_ni(rst), .en_i(rd_cnt_q < CNT_MAX),
    .s_valid_i(s_ar_valid), .s_ready_o(s_ar_ready), .s_data_i({s_ar_addr, s_ar_id}),
    .m_valid_o(m_ar_valid), .m_ready_i(m_ar_ready), .m_data_o({m_ar_addr, m_ar_id}),
    .full_o(ar_full)
  );

  assign m_aw_len   = 8'd0;
  assign m_aw_size  = axsize(DATA_W);
  assign m_aw_burst = BURST_INCR;
  assign m_aw_prot  = PROT;
  assign m_ar_len   = 8'd0;
  assign m_ar_size  = axsize(DATA_W);
  assign m_ar_burst = BURST_INCR;
  assign m_ar_prot  = PROT;

  // Response channels are straight wires.
  assign s_b_valid = m_b_valid;
  assign s_b_id    = m_b_id;
  assign s_b_resp  = m_b_resp;
  assign m_b_ready = s_b_ready;
  assign s_r_valid = m_r_valid;
  assign s_r_data  = m_r_data;
  assign s_r_id    = m_r_id;
  assign s_r_resp  = m_r_resp;
  assign s_r_last  = m_r_last;
  assign m_r_ready = s_r_ready;

  assign aw_hs     = s_aw_valid && s_aw_ready;
  assign ar_hs     = s_ar_valid && s_ar_ready;
  assign b_hs      = m_b_valid && s_b_ready;
  assign r_last_hs = m_r_valid && s_r_ready && m_r_last;
  assign b_err     = b_hs && (m_b_resp != RESP_OKAY);
  assign r_err     = r_last_hs && (m_r_resp != RESP_OKAY);

  assign rd_cnt_d  = cnt_next(rd_cnt_q, ar_hs, r_last_hs);
  assign wr_cnt_d  = cnt_next(wr_cnt_q, aw_hs, b_hs);

  assign err_sum   = {1'b0, err_cnt_q} + 9'(b_err) + 9'(r_err);
  assign err_cnt_d = sat_add8(err_sum);

  // Capture is allowed when empty or being cleared this cycle; B wins over R.
  always_comb begin
    err_valid_d = err_valid_q;
    err_resp_d  = err_resp_q;
    err_id_d    = err_id_q;
    err_is_wr_d = err_is_wr_q;
    if (err_clear) begin
      err_valid_d = 1'b0;
      err_resp_d  = RESP_OKAY;
      err_id_d    = '0;
      err_is_wr_d = 1'b0;
    end
    if ((b_err || r_err) && (!err_valid_q || err_clear)) begin
      err_valid_d = 1'b1;
      err_resp_d  = b_err ? m_b_resp : m_r_resp;
      err_id_d    = b_err ? m_b_id   : m_r_id;
      err_is_wr_d = b_err;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rd_cnt_q    <= '0;
      wr_cnt_q    <= '0;
      err_valid_q <= 1'b0;
      err_resp_q  <= RESP_OKAY;
      err_id_q    <= '0;
      err_is_wr_q <= 1'b0;
      err_cnt_q   <= 8'd0;
    end else begin
      rd_cnt_q    <= rd_cnt_d;
      wr_cnt_q    <= wr_cnt_d;
      err_valid_q <= err_valid_d;
      err_resp_q  <= err_resp_d;
      err_id_q    <= err_id_d;
      err_is_wr_q <= err_is_wr_d;
      err_cnt_q   <= err_cnt_d;
    end
  end

  // A response with nothing outstanding is a protocol violation upstream.
  always_ff @(posedge clk) begin
    if (rst) begin
      assert (!(r_last_hs && !ar_hs && rd_cnt_q == '0));
      assert (!(b_hs && !aw_hs && wr_cnt_q == '0));
    end
  end

  assign err_valid = err_valid_q;
  assign err_resp  = err_resp_q;
  assign err_id    = err_id_q;
  assign err_is_wr = err_is_wr_q;
  assign err_cnt   = err_cnt_q;
  assign idle      = (rd_cnt_q == '0) && (wr_cnt_q == '0) && !aw_full && !w_full && !ar_full;

`ifdef DBUS_BRIDGE_PERF_EN
  logic [31:0] rd_stall_q, wr_stall_q;
  logic [15:0] cyc_q, ts_q, lat_max_q, lat_cur;
  logic        m_ar_hs;

  assign m_ar_hs = m_ar_valid && m_ar_ready;
  assign lat_cur = cyc_q - ts_q;

  // One timestamp only, so latency is meaningful only with a single read in flight.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rd_stall_q <= 32'd0;
      wr_stall_q <= 32'd0;
      cyc_q      <= 16'd0;
      ts_q       <= 16'd0;
      lat_max_q  <= 16'd0;
    end else begin
      cyc_q <= cyc_q + 16'd1;
      if (s_ar_valid && !s_ar_ready) rd_stall_q <= rd_stall_q + 32'd1;
      if (s_aw_valid && !s_aw_ready) wr_stall_q <= wr_stall_q + 32'd1;
      if (m_ar_hs) ts_q <= cyc_q;
      if (r_last_hs && rd_cnt_q == CNT_W'(1) && lat_cur > lat_max_q) lat_max_q <= lat_cur;
    end
  end

  assign perf_rd_stall   = rd_stall_q;
  assign perf_wr_stall   = wr_stall_q;
  assign perf_rd_lat_max = lat_max_q;
`endif

endmodule

// File: tb/tb_axi_dbus_bridge.sv
module tb_axi_dbus_bridge;

  logic        clk = 1'b0;
  logic        rst;
  logic        s_aw_valid, s_aw_ready;
  logic [31:0] s_aw_addr;
  logic [7:0]  s_aw_id;
  logic        s_w_valid, s_w_ready;
  logic [31:0] s_w_data;
  logic [3:0]  s_w_strb;
  logic        s_w_last;
  logic        s_b_valid, s_b_ready;
  logic [7:0]  s_b_id;
  logic [1:0]  s_b_resp;
  logic        s_ar_valid, s_ar_ready;
  logic [31:0] s_ar_addr;
  logic [7:0]  s_ar_id;
  logic        s_r_valid, s_r_ready;
  logic [31:0] s_r_data;
  logic [7:0]  s_r_id;
  logic [1:0]  s_r_resp;
  logic        s_r_last;
  logic        m_aw_valid, m_aw_ready;
  logic [31:0] m_aw_addr;
  logic [7:0]  m_aw_id, m_aw_len;
  logic [2:0]  m_aw_size, m_aw_prot;
  logic [1:0]  m_aw_burst;
  logic        m_w_valid, m_w_ready;
  logic [31:0] m_w_data;
  logic [3:0]  m_w_strb;
  logic        m_w_last;
  logic        m_b_valid, m_b_ready;
  logic [7:0]  m_b_id;
  logic [1:0]  m_b_resp;
  logic        m_ar_valid, m_ar_ready;
  logic [31:0] m_ar_addr;
  logic [7:0]  m_ar_id, m_ar_len;
  logic [2:0]  m_ar_size, m_ar_prot;
  logic [1:0]  m_ar_burst;
  logic        m_r_valid, m_r_ready;
  logic [31:0] m_r_data;
  logic [7:0]  m_r_id;
  logic [1:0]  m_r_resp;
  logic        m_r_last;
  logic        err_valid, err_is_wr, err_clear, idle;
  logic [1:0]  err_resp;
  logic [7:0]  err_id, err_cnt;
`ifdef DBUS_BRIDGE_PERF_EN
  logic [31:0] perf_rd_stall, perf_wr_stall;
  logic [15:0] perf_rd_lat_max;
`endif

  int n_chk  = 0;
  int n_pass = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  axi_dbus_bridge dut (
    .clk(clk), .rst(rst),
    .s_aw_valid(s_aw_valid), .s_aw_ready(s_aw_ready), .s_aw_addr(s_aw_addr), .s_aw_id(s_aw_id),
    .s_w_valid(s_w_valid), .s_w_ready(s_w_ready), .s_w_data(s_w_data), .s_w_strb(s_w_strb),
    .s_w_last(s_w_last),
    .s_b_valid(s_b_valid), .s_b_ready(s_b_ready), .s_b_id(s_b_id), .s_b_resp(s_b_resp),
    .s_ar_valid(s_ar_valid), .s_ar_ready(s_ar_ready), .s_ar_addr(s_ar_addr), .s_ar_id(s_ar_id),
    .s_r_valid(s_r_valid), .s_r_ready(s_r_ready), .s_r_data(s_r_data), .s_r_id(s_r_id),
    .s_r_resp(s_r_resp), .s_r_last(s_r_last),
    .m_aw_valid(m_aw_valid), .m_aw_ready(m_aw_ready), .m_aw_addr(m_aw_addr), .m_aw_id(m_aw_id),
    .m_aw_len(m_aw_len), .m_aw_size(m_aw_size), .m_aw_burst(m_aw_burst), .m_aw_prot(m_aw_prot),
    .m_w_valid(m_w_valid), .m_w_ready(m_w_ready), .m_w_data(m_w_data), .m_w_strb(m_w_strb),
    .m_w_last(m_w_last),
    .m_b_valid(m_b_valid), .m_b_ready(m_b_ready), .m_b_id(m_b_id), .m_b_resp(m_b_resp),
    .m_ar_valid(m_ar_valid), .m_ar_ready(m_ar_ready), .m_ar_addr(m_ar_addr), .m_ar_id(m_ar_id),
    .m_ar_len(m_ar_len), .m_ar_size(m_ar_size), .m_ar_burst(m_ar_burst), .m_ar_prot(m_ar_prot),
    .m_r_valid(m_r_valid), .m_r_ready(m_r_ready), .m_r_data(m_r_data), .m_r_id(m_r_id),
    .m_r_resp(m_r_resp), .m_r_last(m_r_last),
    .err_valid(err_valid), .err_resp(err_resp), .err_id(err_id), .err_is_wr(err_is_wr),
    .err_cnt(err_cnt), .err_clear(err_clear), .idle(idle)
`ifdef DBUS_BRIDGE_PERF_EN
    , .perf_rd_stall(perf_rd_stall), .perf_wr_stall(perf_wr_stall),
    .perf_rd_lat_max(perf_rd_lat_max)
`endif
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_chk++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish within time limit");
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst = 1'b0;
    s_aw_valid = 0; s_aw_addr = '0; s_aw_id = '0;
    s_w_valid = 0; s_w_data = '0; s_w_strb = '0; s_w_last = 0;
    s_b_ready = 1; s_ar_valid = 0; s_ar_addr = '0; s_ar_id = '0; s_r_ready = 1;
    m_aw_ready = 1; m_w_ready = 1; m_ar_ready = 1;
    m_b_valid = 0; m_b_id = '0; m_b_resp = '0;
    m_r_valid = 0; m_r_data = '0; m_r_id = '0; m_r_resp = '0; m_r_last = 0;
    err_clear = 0;

    // reset state
    repeat (2) @(negedge clk);
    chk("rst_m_aw_valid", 64'(m_aw_valid), 64'd0);
    chk("rst_m_w_valid",  64'(m_w_valid),  64'd0);
    chk("rst_m_ar_valid", 64'(m_ar_valid), 64'd0);
    chk("rst_idle",       64'(idle),       64'd1);
    chk("rst_err_valid",  64'(err_valid),  64'd0);
    chk("rst_err_cnt",    64'(err_cnt),    64'd0);
    rst = 1'b1;
    @(negedge clk);

    // single read
    s_ar_valid = 1; s_ar_addr = 32'h0000_1000; s_ar_id = 8'h03;
    #1 chk("t1_s_ar_ready", 64'(s_ar_ready), 64'd1);
    @(negedge clk);
    s_ar_valid = 0;
    #1;
    chk("t1_m_ar_valid", 64'(m_ar_valid), 64'd1);
    chk("t1_m_ar_addr",  64'(m_ar_addr),  64'h1000);
    chk("t1_m_ar_id",    64'(m_ar_id),    64'h03);
    chk("t1_m_ar_len",   64'(m_ar_len),   64'd0);
    chk("t1_m_ar_size",  64'(m_ar_size),  64'd2);
    chk("t1_m_ar_burst", 64'(m_ar_burst), 64'd1);
    chk("t1_m_ar_prot",  64'(m_ar_prot),  64'd0);
    chk("t1_busy",       64'(idle),       64'd0);
    @(negedge clk);
    #1;
    chk("t1_m_ar_drained", 64'(m_ar_valid), 64'd0);
    chk("t1_outstanding",  64'(idle),       64'd0);
    m_r_valid = 1; m_r_last = 1; m_r_data = 32'hCAFE_0001; m_r_id = 8'h03; m_r_resp = 2'b00;
    #1;
    chk("t1_s_r_valid", 64'(s_r_valid), 64'd1);
    chk("t1_s_r_data",  64'(s_r_data),  64'hCAFE_0001);
    chk("t1_m_r_ready", 64'(m_r_ready), 64'd1);
    @(negedge clk);
    m_r_valid = 0;
    #1 chk("t1_idle_back", 64'(idle), 64'd1);

    // outstanding-read limit
    @(negedge clk);
    s_ar_valid = 1;
    for (int i = 0; i < 5; i++) begin
      s_ar_addr = 32'h2000 + 32'(i) * 4;
      s_ar_id   = 8'(i);
      #1 chk($sformatf("t2_ar_ready_%0d", i), 64'(s_ar_ready), (i < 4) ? 64'd1 : 64'd0);
      if (i < 4) @(negedge clk);
    end
    m_r_valid = 1; m_r_last = 1; m_r_resp = 2'b00;
    #1 chk("t2_no_same_cycle_credit", 64'(s_ar_ready), 64'd0);
    @(negedge clk);
    m_r_valid = 0;
    #1 chk("t2_fifth_accepted", 64'(s_ar_ready), 64'd1);
    @(negedge clk);
    s_ar_valid = 0;
    #1;
    chk("t2_full_again",   64'(s_ar_ready), 64'd0);
    chk("t2_fifth_m_addr", 64'(m_ar_addr),  64'h2010);
    m_r_valid = 1;
    repeat (4) @(negedge clk);
    m_r_valid = 0;
    #1 chk("t2_idle_after_drain", 64'(idle), 64'd1);

    // AW stall with stable payload
    m_aw_ready = 0;
    s_aw_valid = 1; s_aw_addr = 32'hDEAD_BEE0; s_aw_id = 8'h01;
    #1 chk("t3_aw_ready_empty", 64'(s_aw_ready), 64'd1);
    @(negedge clk);
    s_aw_addr = 32'h1111_0000; s_aw_id = 8'h02;
    #1;
    chk("t3_m_aw_valid", 64'(m_aw_valid), 64'd1);
    chk("t3_m_aw_addr",  64'(m_aw_addr),  64'hDEAD_BEE0);
    chk("t3_aw_ready_full", 64'(s_aw_ready), 64'd0);
    for (int k = 0; k < 2; k++) begin
      @(negedge clk);
      #1;
      chk($sformatf("t3_stall_addr_%0d", k),  64'(m_aw_addr),  64'hDEAD_BEE0);
      chk($sformatf("t3_stall_ready_%0d", k), 64'(s_aw_ready), 64'd0);
    end
    @(negedge clk);
    m_aw_ready = 1;
    #1;
    chk("t3_aw_ready_passthru", 64'(s_aw_ready), 64'd1);
    chk("t3_addr_before_move",  64'(m_aw_addr),  64'hDEAD_BEE0);
    @(negedge clk);
    s_aw_valid = 0;
    #1;
    chk("t3_second_addr", 64'(m_aw_addr), 64'h1111_0000);
    chk("t3_second_id",   64'(m_aw_id),   64'h02);
    @(negedge clk);
    m_b_valid = 1; m_b_id = 8'h01; m_b_resp = 2'b00;
    #1;
    chk("t3_s_b_valid", 64'(s_b_valid), 64'd1);
    chk("t3_s_b_id",    64'(s_b_id),    64'h01);
    @(negedge clk);
    m_b_id = 8'h02;
    @(negedge clk);
    m_b_valid = 0;
    #1 chk("t3_idle", 64'(idle), 64'd1);

    // eight back-to-back writes
    for (int k = 0; k < 8; k++) begin
      @(negedge clk);
      s_aw_valid = 1; s_aw_addr = 32'h3000 + 32'(k) * 4; s_aw_id = 8'(k);
      s_w_valid = 1; s_w_data = 32'hA000_0000 + 32'(k); s_w_strb = 4'hF; s_w_last = 1;
      m_b_valid = (k > 0); m_b_id = 8'(k - 1);
      #1;
      chk($sformatf("t3b_aw_ready_%0d", k), 64'(s_aw_ready), 64'd1);
      chk($sformatf("t3b_w_ready_%0d", k),  64'(s_w_ready),  64'd1);
      if (k > 0) begin
        chk($sformatf("t3b_aw_addr_%0d", k), 64'(m_aw_addr), 64'(32'h3000 + 32'(k - 1) * 4));
        chk($sformatf("t3b_w_data_%0d", k),  64'(m_w_data),  64'(32'hA000_0000 + 32'(k - 1)));
      end
    end
    @(negedge clk);
    s_aw_valid = 0; s_w_valid = 0; m_b_valid = 1; m_b_id = 8'h07;
    #1;
    chk("t3b_last_valid", 64'(m_aw_valid), 64'd1);
    chk("t3b_last_addr",  64'(m_aw_addr),  64'h301C);
    chk("t3b_last_data",  64'(m_w_data),   64'hA000_0007);
    @(negedge clk);
    m_b_valid = 0;
    #1 chk("t3b_idle", 64'(idle), 64'd1);

    // error capture: B SLVERR then R DECERR
    s_aw_valid = 1; s_aw_addr = 32'h4000; s_aw_id = 8'h05;
    s_ar_valid = 1; s_ar_addr = 32'h4100; s_ar_id = 8'h06;
    @(negedge clk);
    s_aw_valid = 0; s_ar_valid = 0;
    m_b_valid = 1; m_b_id = 8'h05; m_b_resp = 2'b10;
    #1 chk("t4_not_yet", 64'(err_valid), 64'd0);
    @(negedge clk);
    m_b_valid = 0;
    m_r_valid = 1; m_r_last = 1; m_r_id = 8'h06; m_r_resp = 2'b11;
    #1;
    chk("t4_b_err_cnt", 64'(err_cnt), 64'd1);
    @(negedge clk);
    m_r_valid = 0;
    #1;
    chk("t4_err_valid", 64'(err_valid), 64'd1);
    chk("t4_err_resp",  64'(err_resp),  64'd2);
    chk("t4_err_id",    64'(err_id),    64'h05);
    chk("t4_err_is_wr", 64'(err_is_wr), 64'd1);
    chk("t4_err_cnt",   64'(err_cnt),   64'd2);
    err_clear = 1;
    @(negedge clk);
    err_clear = 0;
    #1;
    chk("t4_clr_valid", 64'(err_valid), 64'd0);
    chk("t4_clr_resp",  64'(err_resp),  64'd0);
    chk("t4_clr_id",    64'(err_id),    64'd0);
    chk("t4_clr_cnt",   64'(err_cnt),   64'd2);

    // same-cycle B and R errors, then clear racing a new error
    s_aw_valid = 1; s_aw_addr = 32'h4200; s_aw_id = 8'h09;
    s_ar_valid = 1; s_ar_addr = 32'h4300; s_ar_id = 8'h08;
    @(negedge clk);
    s_aw_valid = 0; s_ar_addr = 32'h4304; s_ar_id = 8'h0A;
    @(negedge clk);
    s_ar_valid = 0;
    m_b_valid = 1; m_b_id = 8'h09; m_b_resp = 2'b10;
    m_r_valid = 1; m_r_last = 1; m_r_id = 8'h08; m_r_resp = 2'b11;
    @(negedge clk);
    m_b_valid = 0;
    m_r_id = 8'h0A; m_r_resp = 2'b11;
    err_clear = 1;
    #1;
    chk("t4b_both_id",    64'(err_id),    64'h09);
    chk("t4b_both_is_wr", 64'(err_is_wr), 64'd1);
    chk("t4b_both_cnt",   64'(err_cnt),   64'd4);
    @(negedge clk);
    m_r_valid = 0; err_clear = 0;
    #1;
    chk("t4b_race_valid", 64'(err_valid), 64'd1);
    chk("t4b_race_id",    64'(err_id),    64'h0A);
    chk("t4b_race_is_wr", 64'(err_is_wr), 64'd0);
    chk("t4b_race_resp",  64'(err_resp),  64'd3);
    chk("t4b_race_cnt",   64'(err_cnt),   64'd5);
    chk("t4b_idle",       64'(idle),      64'd1);

    // asynchronous reset with traffic in flight
    s_ar_valid = 1; s_ar_addr = 32'h5000; s_ar_id = 8'h01;
    @(negedge clk);
    s_ar_id = 8'h02;
    @(negedge clk);
    s_ar_valid = 0;
    m_aw_ready = 0; s_aw_valid = 1; s_aw_addr = 32'h5100; s_aw_id = 8'h03;
    @(negedge clk);
    s_aw_valid = 0;
    #1;
    chk("t5_aw_full", 64'(m_aw_valid), 64'd1);
    chk("t5_busy",    64'(idle),       64'd0);
    #2 rst = 1'b0;
    #1;
    chk("t5_m_aw_valid", 64'(m_aw_valid), 64'd0);
    chk("t5_m_ar_valid", 64'(m_ar_valid), 64'd0);
    chk("t5_m_w_valid",  64'(m_w_valid),  64'd0);
    chk("t5_idle",       64'(idle),       64'd1);
    chk("t5_err_valid",  64'(err_valid),  64'd0);
    chk("t5_err_cnt",    64'(err_cnt),    64'd0);
    @(negedge clk);
    rst = 1'b1; m_aw_ready = 1;
    #1 chk("t5_idle_after", 64'(idle), 64'd1);

    // error counter saturation
    @(negedge clk);
    s_ar_valid = 1; s_ar_addr = 32'h6000; s_ar_id = 8'h00;
    for (int n = 0; n < 256; n++) begin
      @(negedge clk);
      s_ar_valid = (n < 255);
      m_r_valid = 1; m_r_last = 1; m_r_resp = 2'b10; m_r_id = 8'(n);
      #1;
      if (n == 254) chk("t6_cnt_254", 64'(err_cnt), 64'd254);
    end
    @(negedge clk);
    m_r_valid = 0; s_ar_valid = 0;
    #1;
    chk("t6_cnt_sat",   64'(err_cnt),   64'd255);
    chk("t6_first_id",  64'(err_id),    64'h00);
    chk("t6_is_wr",     64'(err_is_wr), 64'd0);
    chk("t6_resp",      64'(err_resp),  64'd2);
    chk("t6_idle",      64'(idle),      64'd1);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
